// File: rtl/segway_math_pipe.sv
// Three-stage Segway drive math: soft-start scaling and steering (S1), mix and dead-zone
// shaping (S2), saturation and persistence-filtered over-speed flag (S3).
module segway_math_pipe #(
  parameter int unsigned PID_W       = 12,
  parameter int unsigned SPD_W       = 12,
  parameter int unsigned MIN_DUTY    = 'hA8,
  parameter int unsigned LOW_BAND    = 'h2A,
  parameter int unsigned GAIN_MULT   = 4,
  parameter int unsigned FAST_THRESH = 1536,
  parameter int unsigned FAST_CNT    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld,
  input  logic [PID_W-1:0] PID_cntrl,
  input  logic [11:0]      steer_pot,
  input  logic             en_steer,
  input  logic             pwr_up,
  output logic [SPD_W-1:0] lft_spd,
  output logic [SPD_W-1:0] rght_spd,
  output logic             spd_vld,
  output logic             too_fast
);

  localparam int unsigned TW = SPD_W + 1;
  localparam int unsigned PW = PID_W + 9;
  localparam int unsigned CW = $clog2(FAST_CNT + 1);

  localparam logic signed [TW-1:0]    MIN_T  = TW'(MIN_DUTY);
  localparam logic signed [TW-1:0]    GAIN_T = TW'(GAIN_MULT);
  localparam logic [TW-1:0]           BAND_T = TW'(LOW_BAND);
  localparam logic [TW-1:0]           FAST_T = TW'(FAST_THRESH);
  localparam logic [CW-1:0]           CNT_MAX = CW'(FAST_CNT);
  localparam logic signed [SPD_W-1:0] SMAX = {1'b0, {(SPD_W-1){1'b1}}};
  localparam logic signed [SPD_W-1:0] SMIN = {1'b1, {(SPD_W-1){1'b0}}};

  // Dead-zone shaping: offset outside the band, gain inside it.
  function automatic logic signed [TW-1:0] shape_f(input logic signed [TW-1:0] t);
    logic [TW-1:0] mag;
    mag = t[TW-1] ? -t : t;
    if (mag > BAND_T) shape_f = t[TW-1] ? t - MIN_T : t + MIN_T;
    else              shape_f = t * GAIN_T;
  endfunction

  function automatic logic signed [SPD_W-1:0] sat_f(input logic signed [TW-1:0] t);
    if (t > TW'(SMAX))      sat_f = SMAX;
    else if (t < TW'(SMIN)) sat_f = SMIN;
    else                    sat_f = t[SPD_W-1:0];
  endfunction

  function automatic logic [TW-1:0] mag_f(input logic signed [SPD_W-1:0] s);
    logic signed [TW-1:0] ext;
    ext   = TW'(s);
    mag_f = s[SPD_W-1] ? -ext : ext;
  endfunction

  logic [7:0]              ss_tmr_q, ss_tmr_d;
  logic signed [PW-1:0]    pid_prod_c;
  logic signed [TW-1:0]    pid_ss_c, pid_ss_q;
  logic [11:0]             clip_c;
  logic signed [12:0]      sig_c, steer_c, steer_q;
  logic                    en_q, pwr_q, v1_q, v2_q;
  logic signed [TW-1:0]    steer_t_c, lft_t_c, rght_t_c;
  logic signed [TW-1:0]    lft_sh_d, rght_sh_d, lft_sh_q, rght_sh_q;
  logic signed [SPD_W-1:0] lft_sat_c, rght_sat_c;
  logic                    over_c;
  logic [CW-1:0]           cnt_q, cnt_d;

  // Soft-start timer: cleared while powered down, saturating count of samples otherwise.
  always_comb begin
    ss_tmr_d = ss_tmr_q;
    if (!pwr_up)                         ss_tmr_d = '0;
    else if (vld && ss_tmr_q != 8'hFF)   ss_tmr_d = ss_tmr_q + 8'd1;
  end

  // S1 math: ramp-scaled PID and 3/16 of the centred, clipped steering reading.
  always_comb begin
    pid_prod_c = PW'($signed(PID_cntrl)) * PW'($signed({1'b0, ss_tmr_q}));
    pid_ss_c   = TW'(pid_prod_c >>> 8);
    clip_c     = (steer_pot < 12'h200) ? 12'h200 :
                 (steer_pot > 12'hE00) ? 12'hE00 : steer_pot;
    sig_c      = $signed({1'b0, clip_c}) - 13'sh7FF;
    steer_c    = (sig_c >>> 3) + (sig_c >>> 4);
  end

  // S2 math: steering mix then shaping; samples captured powered-down drive zero.
  always_comb begin
    steer_t_c = TW'(steer_q);
    lft_t_c   = en_q ? pid_ss_q + steer_t_c : pid_ss_q;
    rght_t_c  = en_q ? pid_ss_q - steer_t_c : pid_ss_q;
    lft_sh_d  = pwr_q ? shape_f(lft_t_c)  : '0;
    rght_sh_d = pwr_q ? shape_f(rght_t_c) : '0;
  end

  // S3 math: saturation and over-speed persistence count.
  always_comb begin
    lft_sat_c  = sat_f(lft_sh_q);
    rght_sat_c = sat_f(rght_sh_q);
    over_c     = (mag_f(lft_sat_c) > FAST_T) || (mag_f(rght_sat_c) > FAST_T);
    cnt_d      = cnt_q;
    if (v2_q) begin
      if (!over_c)              cnt_d = '0;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_tmr_q  <= '0;
      pid_ss_q  <= '0;
      steer_q   <= '0;
      en_q      <= 1'b0;
      pwr_q     <= 1'b0;
      v1_q      <= 1'b0;
      lft_sh_q  <= '0;
      rght_sh_q <= '0;
      v2_q      <= 1'b0;
      cnt_q     <= '0;
      lft_spd   <= '0;
      rght_spd  <= '0;
      spd_vld   <= 1'b0;
      too_fast  <= 1'b0;
    end else begin
      ss_tmr_q <= ss_tmr_d;
      v1_q     <= vld;
      if (vld) begin
        pid_ss_q <= pid_ss_c;
        steer_q  <= steer_c;
        en_q     <= en_steer;
        pwr_q    <= pwr_up;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        lft_sh_q  <= lft_sh_d;
        rght_sh_q <= rght_sh_d;
      end
      spd_vld <= v2_q;
      cnt_q   <= cnt_d;
      if (v2_q) begin
        lft_spd  <= lft_sat_c;
        rght_spd <= rght_sat_c;
        too_fast <= (cnt_d == CNT_MAX);
      end
    end
  end

endmodule

// File: tb/tb_segway_math_pipe.sv
// Scoreboard bench for segway_math_pipe: directed samples push expected outputs,
// a negedge monitor pops and compares on every spd_vld.
module tb_segway_math_pipe;

  logic        clk = 1'b0;
  logic        rst_n, vld, en_steer, pwr_up;
  logic [11:0] PID_cntrl, steer_pot;
  logic [11:0] lft_spd, rght_spd;
  logic        spd_vld, too_fast;

  typedef struct packed {
    logic [11:0] l;
    logic [11:0] r;
    logic        tf;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  segway_math_pipe dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .PID_cntrl(PID_cntrl), .steer_pot(steer_pot),
    .en_steer(en_steer), .pwr_up(pwr_up), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .spd_vld(spd_vld), .too_fast(too_fast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every output strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (spd_vld) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_spd_vld: got spd_vld=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("lft_spd",  32'(lft_spd),  32'(e.l));
        chk("rght_spd", 32'(rght_spd), 32'(e.r));
        chk("too_fast", 32'(too_fast), 32'(e.tf));
        chk("latency",  cyc,           e.cyc);
      end
    end
  end

  task automatic send(input logic [11:0] pid, input logic [11:0] pot, input logic en,
                      input logic push, input logic [11:0] el, input logic [11:0] er,
                      input logic etf);
    @(negedge clk);
    vld       = 1'b1;
    PID_cntrl = pid;
    steer_pot = pot;
    en_steer  = en;
    if (push) sb_q.push_back('{l: el, r: er, tf: etf, cyc: cyc + 3});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vld = 1'b0;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 50) begin
      @(negedge clk);
      vld = 1'b0;
      w++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b1; vld = 1'b0; PID_cntrl = '0; steer_pot = 12'h7FF;
    en_steer = 1'b0; pwr_up = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    chk("rst_lft",      32'(lft_spd),  0);
    chk("rst_rght",     32'(rght_spd), 0);
    chk("rst_spd_vld",  32'(spd_vld),  0);
    chk("rst_too_fast", 32'(too_fast), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp the soft-start timer to 255 with zero drive.
    repeat (255) send(12'h000, 12'h7FF, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0);

    // Full-scale offset path, then hold between strobes.
    send(12'h100, 12'h7FF, 1'b0, 1'b1, 12'h1A7, 12'h1A7, 1'b0);
    idle(6);
    chk("hold_lft",     32'(lft_spd), 32'h1A7);
    chk("hold_spd_vld", 32'(spd_vld), 0);

    // Negative offset path and low-band gain path.
    send(12'hF00, 12'h7FF, 1'b0, 1'b1, 12'hE59, 12'hE59, 1'b0);
    send(12'h00B, 12'h7FF, 1'b0, 1'b1, 12'h028, 12'h028, 1'b0);

    // Steering at both clip limits.
    send(12'h100, 12'hFFF, 1'b1, 1'b1, 12'h2C7, 12'hF7C, 1'b0);
    send(12'h100, 12'h000, 1'b1, 1'b1, 12'hF7C, 12'h2C7, 1'b0);

    // Saturation and over-speed persistence; first in-range sample clears the flag.
    send(12'h7FF, 12'h7FF, 1'b0, 1'b1, 12'h7FF, 12'h7FF, 1'b0);
    send(12'h7FF, 12'h7FF, 1'b0, 1'b1, 12'h7FF, 12'h7FF, 1'b0);
    send(12'h7FF, 12'h7FF, 1'b0, 1'b1, 12'h7FF, 12'h7FF, 1'b0);
    send(12'h7FF, 12'h7FF, 1'b0, 1'b1, 12'h7FF, 12'h7FF, 1'b1);
    send(12'h7FF, 12'h7FF, 1'b0, 1'b1, 12'h7FF, 12'h7FF, 1'b1);
    send(12'h000, 12'h7FF, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0);
    idle(4);

    // In-flight sample keeps its captured pwr_up after power drops.
    send(12'h100, 12'h7FF, 1'b0, 1'b1, 12'h1A7, 12'h1A7, 1'b0);
    @(negedge clk);
    vld    = 1'b0;
    pwr_up = 1'b0;
    drain();

    // Soft-start restart: timer at 0 after power-up, and cleared while powered down.
    @(negedge clk);
    pwr_up = 1'b1;
    send(12'h100, 12'h7FF, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0);
    send(12'h100, 12'h7FF, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0);
    pwr_up = 1'b0;
    send(12'h7FF, 12'h7FF, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0);
    idle(3);
    @(negedge clk);
    pwr_up = 1'b1;
    send(12'h7FF, 12'h7FF, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0);
    send(12'h7FF, 12'h7FF, 1'b0, 1'b1, 12'h01C, 12'h01C, 1'b0);
    drain();

    // Reset with two samples still in flight.
    send(12'h7FF, 12'h7FF, 1'b0, 1'b1, 12'h03C, 12'h03C, 1'b0);
    send(12'h7FF, 12'h7FF, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0);
    send(12'h7FF, 12'h7FF, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0);
    @(negedge clk);
    vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lft",      32'(lft_spd),  0);
    chk("arst_rght",     32'(rght_spd), 0);
    chk("arst_spd_vld",  32'(spd_vld),  0);
    chk("arst_too_fast", 32'(too_fast), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(8);

    // Timer restarts from 0 after reset.
    send(12'h7FF, 12'h7FF, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0);
    drain();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
